// File: rtl/execute_and_memory_if.sv
// Bundle between decode/operand-fetch and the execute/memory stage: the
// registered control word and operands in, write-back word and redirect out.
interface execute_and_memory_if #(
    parameter int DATA_BITS      = 32,
    parameter int reg_addr_width = 5
);
    logic [DATA_BITS-1:0]      pc_min_two;
    logic                      RW;
    logic [reg_addr_width-1:0] DA;
    logic [1:0]                MD;
    logic [1:0]                BS;
    logic                      PS;
    logic                      MW;
    logic [3:0]                FS;
    logic [reg_addr_width-1:0] SH;
    logic [DATA_BITS-1:0]      BUSA;
    logic [DATA_BITS-1:0]      BUSB;

    logic                      RW_wb;
    logic [reg_addr_width-1:0] DA_wb;
    logic [DATA_BITS-1:0]      BUSD_wb;
    logic [3:0]                flags_wb;
    logic                      branch_taken;
    logic [DATA_BITS-1:0]      branch_addr;

    // Upstream side: presents an instruction, observes write-back and redirect.
    modport master (
        output pc_min_two, RW, DA, MD, BS, PS, MW, FS, SH, BUSA, BUSB,
        input  RW_wb, DA_wb, BUSD_wb, flags_wb, branch_taken, branch_addr
    );

    // Stage side.
    modport slave (
        input  pc_min_two, RW, DA, MD, BS, PS, MW, FS, SH, BUSA, BUSB,
        output RW_wb, DA_wb, BUSD_wb, flags_wb, branch_taken, branch_addr
    );
endinterface

// File: rtl/execute_and_memory.sv
// Execute/memory stage: ALU/shifter, word-addressed data memory, branch
// resolution and squashing of the slots behind a taken branch.
module execute_and_memory #(
    parameter int DATA_BITS      = 32,
    parameter int reg_addr_width = 5,
    parameter int DMEM_ADDR_BITS = 8,
    parameter int SQUASH_SLOTS   = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    execute_and_memory_if.slave bus
);
    localparam int DEPTH = 1 << DMEM_ADDR_BITS;
    localparam int MSB   = DATA_BITS - 1;

    logic [DATA_BITS-1:0]      mem [DEPTH];
    logic [DMEM_ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0]      mem_rdata;

    logic [1:0]           sq_cnt_q, sq_cnt_d;
    logic                 squash;

    logic [DATA_BITS:0]   sum;
    logic [DATA_BITS-1:0] add_b;
    logic                 cin;
    logic                 arith;
    logic [DATA_BITS-1:0] f;
    logic                 flag_v, flag_c, flag_n, flag_z;
    logic [DATA_BITS-1:0] result;

    logic                 taken_raw;
    logic [DATA_BITS-1:0] target;
    logic                 taken;

    assign squash    = (sq_cnt_q != 2'd0);
    assign mem_addr  = bus.BUSA[DMEM_ADDR_BITS-1:0];
    assign mem_rdata = mem[mem_addr];

    // Adder operand selection: every arithmetic code is A + add_b + cin.
    always_comb begin
        add_b = '0;
        cin   = 1'b0;
        arith = 1'b0;
        case (bus.FS)
            4'b0001: begin add_b = '0;       cin = 1'b1; arith = 1'b1; end
            4'b0010: begin add_b = bus.BUSB;  cin = 1'b0; arith = 1'b1; end
            4'b0011: begin add_b = bus.BUSB;  cin = 1'b1; arith = 1'b1; end
            4'b0100: begin add_b = ~bus.BUSB; cin = 1'b0; arith = 1'b1; end
            4'b0101: begin add_b = ~bus.BUSB; cin = 1'b1; arith = 1'b1; end
            4'b0110: begin add_b = '1;       cin = 1'b0; arith = 1'b1; end
            default: ;
        endcase
        sum = {1'b0, bus.BUSA} + {1'b0, add_b} + {{DATA_BITS{1'b0}}, cin};
    end

    // Function unit output and flags.
    always_comb begin
        f = '0;
        case (bus.FS)
            4'b0000, 4'b0111: f = bus.BUSA;
            4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b0110: f = sum[DATA_BITS-1:0];
            4'b1000: f = bus.BUSA & bus.BUSB;
            4'b1001: f = bus.BUSA | bus.BUSB;
            4'b1010: f = bus.BUSA ^ bus.BUSB;
            4'b1011: f = ~bus.BUSA;
            4'b1100: f = bus.BUSB;
            4'b1101: f = bus.BUSB >> bus.SH;
            4'b1110: f = bus.BUSB << bus.SH;
            default: f = '0;
        endcase
        flag_z = (f == '0);
        flag_n = f[MSB];
        flag_c = arith & sum[DATA_BITS];
        // Overflow: both addends share a sign that the sum does not.
        flag_v = arith & (bus.BUSA[MSB] == add_b[MSB]) & (f[MSB] != bus.BUSA[MSB]);
    end

    // Write-back data select.
    always_comb begin
        case (bus.MD)
            2'b01:   result = mem_rdata;
            2'b10:   result = {{(DATA_BITS-1){1'b0}}, flag_n ^ flag_v};
            default: result = f;
        endcase
    end

    // Branch resolution before squash/reset gating.
    always_comb begin
        taken_raw = 1'b0;
        target    = bus.pc_min_two + bus.BUSB;
        case (bus.BS)
            2'b01:   taken_raw = flag_z ^ bus.PS;
            2'b10:   taken_raw = 1'b1;
            2'b11:   begin taken_raw = 1'b1; target = bus.BUSA; end
            default: taken_raw = 1'b0;
        endcase
    end

    // rst_n gates the redirect so it drops immediately, without a clock.
    assign taken            = rst_n & ~squash & taken_raw;
    assign bus.branch_taken = taken;
    assign bus.branch_addr  = taken ? target : '0;

    // Squash counter next state: reload on a live taken branch, else drain.
    always_comb begin
        sq_cnt_d = sq_cnt_q;
        if (taken) begin
            sq_cnt_d = 2'(SQUASH_SLOTS);
        end else if (squash) begin
            sq_cnt_d = sq_cnt_q - 2'd1;
        end
    end

    // Squash counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_cnt_q <= 2'd0;
        end else begin
            sq_cnt_q <= sq_cnt_d;
        end
    end

    // Data memory write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (bus.MW && !squash) begin
            mem[mem_addr] <= bus.BUSB;
        end
    end

    // Write-back register; only RW is suppressed in a squashed slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.RW_wb    <= 1'b0;
            bus.DA_wb    <= '0;
            bus.BUSD_wb  <= '0;
            bus.flags_wb <= 4'b0000;
        end else begin
            bus.RW_wb    <= bus.RW & ~squash;
            bus.DA_wb    <= bus.DA;
            bus.BUSD_wb  <= result;
            bus.flags_wb <= {flag_v, flag_c, flag_n, flag_z};
        end
    end
endmodule

// File: tb/tb_execute_and_memory.sv
// Directed bench for execute_and_memory with a write-back scoreboard.
module tb_execute_and_memory;
    logic clk;
    logic rst_n;

    execute_and_memory_if #(.DATA_BITS(32), .reg_addr_width(5)) bus ();

    execute_and_memory #(
        .DATA_BITS(32), .reg_addr_width(5), .DMEM_ADDR_BITS(8), .SQUASH_SLOTS(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        rw;
        logic [4:0]  da;
        logic [1:0]  md;
        logic [1:0]  bs;
        logic        ps;
        logic        mw;
        logic [3:0]  fs;
        logic [4:0]  sh;
        logic [31:0] a;
        logic [31:0] b;
    } instr_t;

    typedef struct {
        string       name;
        logic        rw;
        logic [4:0]  da;
        logic [31:0] busd;
        logic [3:0]  flags;
        logic        chk_data;
        logic        chk_flags;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic instr_t nop();
        instr_t i;
        i.pc = '0; i.rw = 1'b0; i.da = '0; i.md = '0; i.bs = '0; i.ps = 1'b0;
        i.mw = 1'b0; i.fs = '0; i.sh = '0; i.a = '0; i.b = '0;
        return i;
    endfunction

    task automatic drive(input instr_t i);
        bus.pc_min_two = i.pc; bus.RW = i.rw; bus.DA = i.da; bus.MD = i.md;
        bus.BS = i.bs; bus.PS = i.ps; bus.MW = i.mw; bus.FS = i.fs;
        bus.SH = i.sh; bus.BUSA = i.a; bus.BUSB = i.b;
    endtask

    task automatic issue(input instr_t i);
        @(negedge clk);
        drive(i);
        #1;
    endtask

    task automatic expect_wb(input string name, input logic rw, input logic [4:0] da,
                             input logic [31:0] busd, input logic [3:0] flags,
                             input logic chk_data, input logic chk_flags);
        exp_t e;
        e.name = name; e.rw = rw; e.da = da; e.busd = busd; e.flags = flags;
        e.chk_data = chk_data; e.chk_flags = chk_flags;
        sb.push_back(e);
    endtask

    task automatic chk_br(input string name, input logic taken, input logic [31:0] addr);
        check({name, "_taken"}, 32'(bus.branch_taken), 32'(taken));
        check({name, "_addr"}, bus.branch_addr, addr);
    endtask

    // Monitor: the stage emits a write-back word every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, "_rw"}, 32'(bus.RW_wb), 32'(e.rw));
                if (e.chk_data) begin
                    check({e.name, "_da"}, 32'(bus.DA_wb), 32'(e.da));
                    check({e.name, "_busd"}, bus.BUSD_wb, e.busd);
                end
                if (e.chk_flags) check({e.name, "_flags"}, 32'(bus.flags_wb), 32'(e.flags));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t i;

        // Reset held with a write and an unconditional branch presented.
        rst_n = 1'b0;
        i = nop(); i.rw = 1'b1; i.bs = 2'b10; i.a = 32'h5; i.pc = 32'h10;
        drive(i);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_rw", 32'(bus.RW_wb), 32'd0);
        check("rst_busd", bus.BUSD_wb, 32'd0);
        check("rst_flags", 32'(bus.flags_wb), 32'd0);
        chk_br("rst_br", 1'b0, 32'h0);

        // First post-reset instruction: 5 - 7.
        @(negedge clk);
        rst_n = 1'b1;
        i = nop(); i.rw = 1'b1; i.da = 5'd3; i.fs = 4'b0101; i.a = 32'd5; i.b = 32'd7;
        drive(i); #1;
        expect_wb("sub", 1'b1, 5'd3, 32'hFFFF_FFFE, 4'b0010, 1'b1, 1'b1);
        chk_br("sub_br", 1'b0, 32'h0);

        i = nop(); i.rw = 1'b1; i.da = 5'd4; i.fs = 4'b0010; i.a = 32'h7FFF_FFFF; i.b = 32'd1;
        issue(i); expect_wb("add_ovf", 1'b1, 5'd4, 32'h8000_0000, 4'b1010, 1'b1, 1'b1);

        i = nop(); i.rw = 1'b1; i.da = 5'd5; i.fs = 4'b1110; i.b = 32'd1; i.sh = 5'd31;
        issue(i); expect_wb("shl31", 1'b1, 5'd5, 32'h8000_0000, 4'b0010, 1'b1, 1'b1);

        i = nop(); i.rw = 1'b1; i.da = 5'd6; i.fs = 4'b1101; i.b = 32'h8000_0000; i.sh = 5'd4;
        issue(i); expect_wb("shr4", 1'b1, 5'd6, 32'h0800_0000, 4'b0000, 1'b1, 1'b1);

        i = nop(); i.rw = 1'b1; i.da = 5'd7; i.fs = 4'b0001; i.a = 32'hFFFF_FFFF;
        issue(i); expect_wb("inc_wrap", 1'b1, 5'd7, 32'h0, 4'b0101, 1'b1, 1'b1);

        i = nop(); i.rw = 1'b1; i.da = 5'd8; i.fs = 4'b0110; i.a = 32'h0;
        issue(i); expect_wb("dec0", 1'b1, 5'd8, 32'hFFFF_FFFF, 4'b0010, 1'b1, 1'b1);

        i = nop(); i.rw = 1'b1; i.da = 5'd9; i.fs = 4'b1010; i.a = 32'hF0F0_F0F0;
        i.b = 32'hFF00_FF00;
        issue(i); expect_wb("xor", 1'b1, 5'd9, 32'h0FF0_0FF0, 4'b0000, 1'b1, 1'b1);

        i = nop(); i.rw = 1'b1; i.da = 5'd10; i.fs = 4'b1011; i.a = 32'h0000_FFFF;
        issue(i); expect_wb("not", 1'b1, 5'd10, 32'hFFFF_0000, 4'b0010, 1'b1, 1'b1);

        // Store to a wrapped address, then read back through the low bits.
        i = nop(); i.mw = 1'b1; i.a = 32'h103; i.b = 32'hDEAD;
        issue(i); expect_wb("st_wrap", 1'b0, 5'd0, 32'h103, 4'b0000, 1'b1, 1'b1);

        i = nop(); i.rw = 1'b1; i.da = 5'd11; i.md = 2'b01; i.a = 32'h3;
        issue(i); expect_wb("ld_wrap", 1'b1, 5'd11, 32'hDEAD, 4'b0000, 1'b1, 1'b1);

        // Same-cycle store and load sees the old word.
        i = nop(); i.rw = 1'b1; i.da = 5'd12; i.md = 2'b01; i.mw = 1'b1; i.a = 32'h3;
        i.b = 32'hBEEF;
        issue(i); expect_wb("ld_old", 1'b1, 5'd12, 32'hDEAD, 4'b0000, 1'b1, 1'b1);

        i = nop(); i.rw = 1'b1; i.da = 5'd13; i.md = 2'b01; i.a = 32'h3;
        issue(i); expect_wb("ld_new", 1'b1, 5'd13, 32'hBEEF, 4'b0000, 1'b1, 1'b1);

        // Set-less-than, including a signed-overflow case.
        i = nop(); i.rw = 1'b1; i.da = 5'd14; i.md = 2'b10; i.fs = 4'b0101;
        i.a = 32'hFFFF_FFFD; i.b = 32'd2;
        issue(i); expect_wb("slt_lt", 1'b1, 5'd14, 32'd1, 4'b0110, 1'b1, 1'b1);

        i = nop(); i.rw = 1'b1; i.da = 5'd15; i.md = 2'b10; i.fs = 4'b0101;
        i.a = 32'd2; i.b = 32'hFFFF_FFFD;
        issue(i); expect_wb("slt_ge", 1'b1, 5'd15, 32'd0, 4'b0000, 1'b1, 1'b1);

        i = nop(); i.rw = 1'b1; i.da = 5'd16; i.md = 2'b10; i.fs = 4'b0101;
        i.a = 32'h8000_0000; i.b = 32'd1;
        issue(i); expect_wb("slt_ovf", 1'b1, 5'd16, 32'd1, 4'b1100, 1'b1, 1'b1);

        // Conditional branch on Z: PS=1 not taken, PS=0 taken with a store.
        i = nop(); i.bs = 2'b01; i.ps = 1'b1; i.pc = 32'h10; i.b = 32'h4;
        issue(i); chk_br("bz_ps1", 1'b0, 32'h0);
        expect_wb("bz_ps1", 1'b0, 5'd0, 32'h0, 4'b0001, 1'b1, 1'b1);

        i = nop(); i.bs = 2'b01; i.ps = 1'b0; i.pc = 32'h10; i.b = 32'h4; i.mw = 1'b1;
        issue(i); chk_br("bz_ps0", 1'b1, 32'h14);
        expect_wb("bz_ps0", 1'b0, 5'd0, 32'h0, 4'b0001, 1'b1, 1'b1);

        for (int k = 0; k < 2; k++) begin
            i = nop(); i.rw = 1'b1; i.mw = 1'b1; i.bs = 2'b10; i.a = 32'h3;
            i.b = 32'h5555; i.pc = 32'h50;
            issue(i); chk_br("sq_slot", 1'b0, 32'h0);
            expect_wb("sq_slot", 1'b0, 5'd0, 32'h0, 4'b0000, 1'b0, 1'b0);
        end

        i = nop(); i.rw = 1'b1; i.da = 5'd17; i.md = 2'b01; i.a = 32'h3;
        issue(i); chk_br("post_sq", 1'b0, 32'h0);
        expect_wb("post_sq", 1'b1, 5'd17, 32'hBEEF, 4'b0000, 1'b1, 1'b1);

        i = nop(); i.rw = 1'b1; i.da = 5'd18; i.md = 2'b01; i.a = 32'h0;
        issue(i); expect_wb("br_store", 1'b1, 5'd18, 32'h4, 4'b0001, 1'b1, 1'b1);

        // A branch in a squashed slot must not reload the counter.
        i = nop(); i.bs = 2'b10; i.pc = 32'h100; i.b = 32'h20;
        issue(i); chk_br("br_uncond", 1'b1, 32'h120);
        expect_wb("br_uncond", 1'b0, 5'd0, 32'h0, 4'b0000, 1'b0, 1'b0);

        i = nop(); i.rw = 1'b1; i.bs = 2'b11; i.a = 32'h40;
        issue(i); chk_br("sq_jmp", 1'b0, 32'h0);
        expect_wb("sq_jmp", 1'b0, 5'd0, 32'h0, 4'b0000, 1'b0, 1'b0);

        i = nop(); i.rw = 1'b1;
        issue(i); expect_wb("sq_nop", 1'b0, 5'd0, 32'h0, 4'b0000, 1'b0, 1'b0);

        i = nop(); i.rw = 1'b1; i.da = 5'd19; i.bs = 2'b11; i.a = 32'h44;
        issue(i); chk_br("jmp", 1'b1, 32'h44);
        expect_wb("jmp", 1'b1, 5'd19, 32'h44, 4'b0000, 1'b1, 1'b1);

        // Reset mid-squash: outputs clear without a clock edge.
        i = nop(); i.rw = 1'b1; i.bs = 2'b10; i.pc = 32'h300;
        issue(i); chk_br("sq_pre_rst", 1'b0, 32'h0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_rw", 32'(bus.RW_wb), 32'd0);
        check("mid_rst_busd", bus.BUSD_wb, 32'd0);
        chk_br("mid_rst_br", 1'b0, 32'h0);
        drive(nop());
        @(negedge clk);
        rst_n = 1'b1;
        i = nop(); i.rw = 1'b1; i.da = 5'd20; i.bs = 2'b10; i.pc = 32'h200;
        drive(i); #1;
        chk_br("post_rst_br", 1'b1, 32'h200);
        expect_wb("post_rst", 1'b1, 5'd20, 32'h0, 4'b0001, 1'b1, 1'b1);

        for (int k = 0; k < 2; k++) begin
            i = nop(); i.rw = 1'b1;
            issue(i); expect_wb("sq_after_rst", 1'b0, 5'd0, 32'h0, 4'b0000, 1'b0, 1'b0);
        end

        // Branch if not zero, negative offset.
        i = nop(); i.bs = 2'b01; i.ps = 1'b1; i.a = 32'h1; i.pc = 32'h30; i.b = 32'hFFFF_FFF0;
        issue(i); chk_br("bnz", 1'b1, 32'h20);
        expect_wb("bnz", 1'b0, 5'd0, 32'h1, 4'b0000, 1'b1, 1'b1);

        for (int k = 0; k < 2; k++) begin
            i = nop(); i.rw = 1'b1;
            issue(i); expect_wb("sq_bnz", 1'b0, 5'd0, 32'h0, 4'b0000, 1'b0, 1'b0);
        end

        i = nop(); i.rw = 1'b1; i.da = 5'd31; i.fs = 4'b1111; i.a = 32'h5;
        issue(i); expect_wb("zero_fn", 1'b1, 5'd31, 32'h0, 4'b0001, 1'b1, 1'b1);

        @(negedge clk);
        drive(nop());
        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
